// File: rtl/demux_sched_pkg.sv
// Shared constants and state encoding for the round-robin demux scheduler.
package demux_sched_pkg;

    localparam int NCH  = 4;
    localparam int SELW = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } sched_state_t;

endpackage

// File: rtl/demux_rr_sched_pick.sv
// Combinational round-robin picker: first requester in order ptr+1, ptr+2, ptr+3, ptr (mod 4).
module rr_pick4
    import demux_sched_pkg::*;
(
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] idx,
    output logic            any
);

    logic [SELW-1:0] cand [NCH];
    logic [NCH-1:0]  hit;

    // Candidate gi is the channel visited (gi+1)-th after ptr; the 2-bit add wraps mod 4.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_cand
            assign cand[gi] = ptr + SELW'(gi + 1);
            assign hit[gi]  = req[cand[gi]];
        end
    endgenerate

    always_comb begin
        idx = cand[0];
        for (int i = NCH - 1; i >= 0; i--) begin
            if (hit[i]) begin
                idx = cand[i];
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/demux_rr_sched.sv
// Round-robin burst scheduler sharing one valid/ready stream among four demux channels.
module demux_rr_sched
    import demux_sched_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             in_ready,
    input  logic [NCH-1:0]   ch_en,
    input  logic [NCH-1:0]   out_ready,
    output logic [NCH-1:0]   out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [SELW-1:0]  sel,
    output logic             busy
);

    localparam int CNTW = $clog2(BURST + 1);

    sched_state_t    state_reg;
    logic [SELW-1:0] sel_reg;
    logic [SELW-1:0] ptr_reg;
    logic [CNTW-1:0] cnt_reg;

    logic [SELW-1:0] pick_idx;
    logic            pick_any;
    logic            granted;
    logic            xfer;
    logic            burst_end;

    rr_pick4 u_pick (
        .req (ch_en),
        .ptr (ptr_reg),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign granted = (state_reg == ST_GRANT);

    // Steering is purely combinational so data never picks up a pipeline stage.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_steer
            assign out_valid[gi] = granted && (sel_reg == SELW'(gi)) && in_valid;
        end
    endgenerate

    assign in_ready  = granted && out_ready[sel_reg];
    assign out_data  = in_data;
    assign sel       = sel_reg;
    assign busy      = granted;

    assign xfer      = in_valid && in_ready;
    assign burst_end = xfer && (((int'(cnt_reg) + 1) == BURST) || in_last);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            sel_reg   <= '0;
            ptr_reg   <= 2'd3;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid && pick_any) begin
                        sel_reg   <= pick_idx;
                        cnt_reg   <= '0;
                        state_reg <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (xfer) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                    if (burst_end) begin
                        ptr_reg   <= sel_reg;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_demux_rr_sched.sv
// Directed bench for demux_rr_sched with hand-computed expectations (BURST=4).
module tb_demux_rr_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;
    logic [3:0] ch_en;
    logic [3:0] out_ready;
    logic [3:0] out_valid;
    logic [7:0] out_data;
    logic [1:0] sel;
    logic       busy;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    demux_rr_sched #(.WIDTH(8), .BURST(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .ch_en     (ch_en),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .sel       (sel),
        .busy      (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full-rate beat on channel ch; the edge at the end of the cycle is consumed.
    task automatic beat(input string tag, input logic [1:0] ch);
        logic [3:0] oh;
        oh = 4'b0001 << ch;
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        chk({tag, ".sel"}, 32'(sel), 32'(ch));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(oh));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        step();
    endtask

    task automatic expect_idle(input string tag);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    endtask

    // n beats on channel ch, then the IDLE bubble is checked (no edge consumed after it).
    task automatic expect_burst(input string tag, input logic [1:0] ch, input int n);
        for (int b = 0; b < n; b++) begin
            in_data = 8'(8'h10 * ch + b);
            #1;
            chk({tag, ".out_data"}, 32'(out_data), 32'(8'h10 * ch + b));
            beat(tag, ch);
        end
        expect_idle({tag, ".bubble"});
        $display("burst %s ch=%0d beats=%0d done", tag, ch, n);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
        ch_en = 4'b0000; out_ready = 4'b0000;
        step(); step();
        expect_idle("reset");
        chk("reset.sel", 32'(sel), 32'd0);

        // Reset and first grant
        rst_n = 1'b1; ch_en = 4'b1111; out_ready = 4'b1111; in_valid = 1'b1;
        #1;
        expect_idle("arb0");
        step();
        expect_burst("first", 2'd0, 4);
        step();
        chk("first.next_sel", 32'(sel), 32'd1);

        // Rotation with holes: 1,3,1,3
        ch_en = 4'b1010;
        expect_burst("rot1", 2'd1, 4);
        step();
        expect_burst("rot3", 2'd3, 4);
        step();
        expect_burst("rot1b", 2'd1, 4);
        step();
        expect_burst("rot3b", 2'd3, 4);

        // Early end on in_last at beat 2 of ch2, next grant ch3
        ch_en = 4'b1100;
        step();
        beat("early.b1", 2'd2);
        in_last = 1'b1;
        beat("early.b2", 2'd2);
        in_last = 1'b0;
        expect_idle("early.bubble");
        $display("burst early ch=2 beats=2 done");
        step();
        expect_burst("after_early", 2'd3, 4);

        // Backpressure: 3 stalled cycles mid-burst on ch0
        ch_en = 4'b0001;
        step();
        beat("bp.b1", 2'd0);
        out_ready = 4'b1110;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp.stall.in_ready", 32'(in_ready), 32'd0);
            chk("bp.stall.out_valid", 32'(out_valid), 32'b0001);
            step();
        end
        out_ready = 4'b1111;
        expect_burst("bp.rest", 2'd0, 3);

        // Disable mid-burst: burst still completes 4 beats
        step();
        beat("dis.b1", 2'd0);
        ch_en = 4'b0000;
        expect_burst("dis.rest", 2'd0, 3);
        for (int i = 0; i < 3; i++) begin
            step();
            expect_idle("noen");
        end
        $display("no-enable idle check done");

        // Reset mid-burst during beat 3, then first grant goes to ch0
        ch_en = 4'b1111;
        step();
        beat("rst.b1", 2'd1);
        beat("rst.b2", 2'd1);
        chk("rst.b3.sel", 32'(sel), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        expect_idle("rst.after");
        step();
        chk("rst.regrant.sel", 32'(sel), 32'd0);
        $display("reset mid-burst regrant sel=%0d", sel);

        // in_last on the 4th beat is one burst end
        beat("coinc.b1", 2'd0);
        beat("coinc.b2", 2'd0);
        beat("coinc.b3", 2'd0);
        in_last = 1'b1;
        beat("coinc.b4", 2'd0);
        in_last = 1'b0;
        expect_idle("coinc.bubble");
        step();
        chk("coinc.next_sel", 32'(sel), 32'd1);
        chk("coinc.next_busy", 32'(busy), 32'd1);
        $display("coincident last/burst end next sel=%0d", sel);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
